dct_basis_gen: RTL and testbench
================================

# dct_basis_gen

Sequential generator for the 8x8 2-D DCT basis, replacing the fixed per-(k1,k2) cosine lookup tables. It accepts one frequency pair (k1,k2) per request and streams all 64 signed fixed-point basis terms C(k1)C(k2)·cos((2n1+1)k1π/16)·cos((2n2+1)k2π/16) with valid/ready backpressure. It sits between the DCT sequencer and the MAC datapath.

## Interface
- OUT_W, 32: output term width, two's complement, sign-extended.
- OUT_FRAC, 10: output fraction bits; legal range 0..2·TBL_FRAC.
- ORDER_EN, 1: 1 enables per-request column-major order via `req_col`; 0 ties order to row-major.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, request accepted this cycle when both are high.
- req_k1, req_k2  in  3 each  frequency indices.
- req_col  in  1  1 = n1 varies fastest; 0 = n2 varies fastest.
- out_valid  out  1  term valid.
- out_ready  in  1  consumer accepts.
- out_n1, out_n2  out  3 each  spatial indices of term.
- out_term  out  OUT_W  basis term.
- out_last  out  1  marks 64th term.

## Operation
- 1-D table A[k][n] = round(c(k)·cos((2n+1)kπ/16)·2^TBL_FRAC), with c(0)=√(1/8) and c(k>0)=1/2; TBL_FRAC=14, 16-bit signed.
- Term = A[k1][n1]·A[k2][n2] (32-bit product), scaled by 2^-(2·TBL_FRAC−OUT_FRAC), truncated toward zero, sign-extended to OUT_W.
- FSM states:
  - IDLE: req_ready=1. Handshake latches k1, k2 and order, clears the index counter, then goes to RUN.
  - RUN: issues one index pair per enabled cycle. After index 63 is issued, goes to DRAIN.
  - DRAIN: waits until the last term is accepted, then goes to IDLE.
- Row-major order: (0,0),(0,1)…(0,7),(1,0)…; column-major swaps the roles of n1 and n2.
- req_ready is low in RUN and DRAIN; requests are not accepted or queued.

## Timing
- Three-stage pipeline: ROM read, multiply, scale/round. All stages advance on `en = !out_valid || out_ready`.
- First term is valid 3 cycles after the request handshake.
- Throughput is 1 term per cycle without stall; 64 terms cover cycles 3..66.
- A stall freezes every stage. out_term, out_n1, out_n2 and out_last hold stable while out_valid && !out_ready.
- out_last is high only with index 63.
- Next request can be accepted the cycle after the last term's handshake.
- Reset values: out_valid=0, out_last=0, out_term=0, out_n1=0, out_n2=0. req_ready=1 one cycle after reset release.
- Reset mid-stream discards all in-flight terms; no partial completion.

## Configuration
- DCT_BASIS_ROUND_EN defined: round half away from zero before truncation.
- DCT_BASIS_ROUND_EN undefined: truncation toward zero, bit-exact with the legacy per-pair LUTs.

## Structure
- Package dct_pkg holds:
  - N=8, TBL_FRAC=14, TBL_W=16;
  - the 8x8 constant table A;
  - typedef `dct_idx_t` (logic [2:0]);
  - the FSM state enum.
- One sub-module, dct_cos_rom: registered 1-D lookup with two read ports, forming pipeline stage 1.

## Test plan
- Request (5,6), row-major, out_ready=1:
  - (0,0) → 54 (0x036) at cycle 3;
  - (1,1) → 231 (0xE7);
  - (1,0) → −96;
  - out_last on (7,7).
- Request (0,0): all 64 terms = 128. With DCT_BASIS_ROUND_EN, (5,6) at (1,1) → 232.
- Request (5,6) with req_col=1: second term is (1,0) → −96; term sequence matches the transpose of the row-major run.
- Random out_ready toggling: outputs stay stable during stall; exactly 64 handshakes; order is preserved.
- req_valid held high through a stream: second request accepted only in IDLE; 3-cycle gap to its first term.
- rst_n pulsed at term 20: out_valid=0 immediately; next request restarts at (0,0).

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 DCT basis generator: the 1-D cosine
// table A[k][n] in Q1.14, the spatial/frequency index type and the FSM states.
package dct_pkg;

    localparam int N        = 8;
    localparam int TBL_FRAC = 14;
    localparam int TBL_W    = 16;

    typedef logic [2:0] dct_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dct_state_e;

    // A[k][n] = round(c(k) * cos((2n+1)k*pi/16) * 2^14), c(0)=sqrt(1/8), c(k>0)=1/2
    localparam logic signed [TBL_W-1:0] A [N][N] = '{
        '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
        '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
        '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
        '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
        '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
        '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
        '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
        '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
    };

endpackage

// File: rtl/dct_cos_rom.sv
// Pipeline stage 1: registered two-port lookup into the 1-D cosine table.
// Both ports hold their value while en_i is low.
module dct_cos_rom
    import dct_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  dct_idx_t                k1_i,
    input  dct_idx_t                n1_i,
    input  dct_idx_t                k2_i,
    input  dct_idx_t                n2_i,
    output logic signed [TBL_W-1:0] a1_o,
    output logic signed [TBL_W-1:0] a2_o
);

    logic signed [TBL_W-1:0] a1_q;
    logic signed [TBL_W-1:0] a2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q <= '0;
            a2_q <= '0;
        end else if (en_i) begin
            a1_q <= A[k1_i][n1_i];
            a2_q <= A[k2_i][n2_i];
        end
    end

    assign a1_o = a1_q;
    assign a2_o = a2_q;

endmodule

// File: rtl/dct_basis_gen.sv
// Streams the 64 terms of one 8x8 DCT basis function through a 3-stage
// pipeline (ROM, multiply, scale). Define DCT_BASIS_ROUND_EN for rounding.
module dct_basis_gen
    import dct_pkg::*;
#(
    parameter int OUT_W    = 32,
    parameter int OUT_FRAC = 10,
    parameter int ORDER_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_k1_i,
    input  logic [2:0]       req_k2_i,
    input  logic             req_col_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2:0]       out_n1_o,
    output logic [2:0]       out_n2_o,
    output logic [OUT_W-1:0] out_term_o,
    output logic             out_last_o,
    output logic [1:0]       dbg_state_o
);

    localparam int SHIFT = 2 * TBL_FRAC - OUT_FRAC;
`ifdef DCT_BASIS_ROUND_EN
    localparam logic [31:0] RND_BIAS = (32'd1 << SHIFT) >> 1;
`else
    localparam logic [31:0] RND_BIAS = 32'd0;
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; the producer holds its payload stable until that edge.
    dct_state_e state_q;
    logic       req_ready_q;
    dct_idx_t   k1_q, k2_q;
    logic       col_q;
    logic [5:0] cnt_q;

    logic       en;
    logic       issue;
    dct_idx_t   iss_n1, iss_n2;

    logic signed [TBL_W-1:0] a1, a2;
    logic                    v1_q, last1_q;
    dct_idx_t                n1_s1_q, n2_s1_q;
    logic                    v2_q, last2_q;
    dct_idx_t                n1_s2_q, n2_s2_q;
    logic signed [31:0]      prod_q;
    logic signed [31:0]      a1_ext, a2_ext;

    logic                    out_valid_q, out_last_q;
    dct_idx_t                out_n1_q, out_n2_q;
    logic [OUT_W-1:0]        out_term_q;

    logic                    neg;
    logic [31:0]             mag, qmag;
    logic signed [31:0]      res_s;
    logic [OUT_W-1:0]        term_d;

    assign en    = !out_valid_q || out_ready_i;
    assign issue = (state_q == ST_RUN) && en;

    always_comb begin
        iss_n1 = cnt_q[5:3];
        iss_n2 = cnt_q[2:0];
        if (col_q) begin
            iss_n1 = cnt_q[2:0];
            iss_n2 = cnt_q[5:3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            k1_q        <= '0;
            k2_q        <= '0;
            col_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        k1_q        <= req_k1_i;
                        k2_q        <= req_k2_i;
                        col_q       <= (ORDER_EN != 0) ? req_col_i : 1'b0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd63) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && out_ready_i && out_last_q) begin
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    dct_cos_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .k1_i  (k1_q),
        .n1_i  (iss_n1),
        .k2_i  (k2_q),
        .n2_i  (iss_n2),
        .a1_o  (a1),
        .a2_o  (a2)
    );

    assign a1_ext = 32'(a1);
    assign a2_ext = 32'(a2);

    // Scale via magnitude so both truncation and rounding are symmetric about zero.
    always_comb begin
        neg    = prod_q[31];
        mag    = neg ? 32'(-prod_q) : 32'(prod_q);
        qmag   = (mag + RND_BIAS) >> SHIFT;
        res_s  = neg ? -signed'(qmag) : signed'(qmag);
        term_d = OUT_W'(res_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            n1_s1_q     <= '0;
            n2_s1_q     <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            n1_s2_q     <= '0;
            n2_s2_q     <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_n1_q    <= '0;
            out_n2_q    <= '0;
            out_term_q  <= '0;
        end else if (en) begin
            v1_q        <= issue;
            last1_q     <= issue && (cnt_q == 6'd63);
            n1_s1_q     <= iss_n1;
            n2_s1_q     <= iss_n2;
            v2_q        <= v1_q;
            last2_q     <= last1_q;
            n1_s2_q     <= n1_s1_q;
            n2_s2_q     <= n2_s1_q;
            prod_q      <= a1_ext * a2_ext;
            out_valid_q <= v2_q;
            out_last_q  <= last2_q;
            out_n1_q    <= n1_s2_q;
            out_n2_q    <= n2_s2_q;
            out_term_q  <= term_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_n1_o    = out_n1_q;
    assign out_n2_o    = out_n2_q;
    assign out_term_o  = out_term_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dct_basis_gen.sv
// Self-checking bench for dct_basis_gen: directed and random requests checked
// against a cosine-table model built from real arithmetic.
module tb_dct_basis_gen;

    localparam int OUT_W    = 32;
    localparam int OUT_FRAC = 10;
    localparam int SHIFT_M  = 28 - OUT_FRAC;
    localparam int EW       = 3 + 3 + 1 + 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_k1_i, req_k2_i;
    logic             req_col_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [2:0]       out_n1_o, out_n2_o;
    logic [OUT_W-1:0] out_term_o;
    logic             out_last_o;
    logic [1:0]       dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   seq_term[64];
    logic [2:0]    seq_n1[64], seq_n2[64];
    logic [31:0]   row_term[64];
    logic [2:0]    next_k1, next_k2;
    logic          next_col;

    always #5 clk = ~clk;

    dct_basis_gen #(.OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .ORDER_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_k1_i    (req_k1_i),
        .req_k2_i    (req_k2_i),
        .req_col_i   (req_col_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_n1_o    (out_n1_o),
        .out_n2_o    (out_n2_o),
        .out_term_o  (out_term_o),
        .out_last_o  (out_last_o),
        .dbg_state_o (dbg_state_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] t32(input int v);
        return v[31:0];
    endfunction

    function automatic int tbl_a(input int k, input int n);
        real c, v;
        c = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        v = c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0) * 16384.0;
        if (v >= 0.0) return $rtoi(v + 0.5);
        return $rtoi(v - 0.5);
    endfunction

    function automatic logic [31:0] model_term(input int k1, input int k2, input int n1, input int n2);
        longint p, d, q;
        p = longint'(tbl_a(k1, n1)) * longint'(tbl_a(k2, n2));
        d = longint'(1) << SHIFT_M;
`ifdef DCT_BASIS_ROUND_EN
        q = ((p < 0 ? -p : p) + d / 2) / d;
        if (p < 0) q = -q;
`else
        q = p / d;
`endif
        return q[31:0];
    endfunction

    task automatic push_stream(input int k1, input int k2, input bit col);
        int n1, n2;
        for (int i = 0; i < 64; i++) begin
            n1 = col ? i % 8 : i / 8;
            n2 = col ? i / 8 : i % 8;
            exp_q.push_back({3'(n1), 3'(n2), (i == 63), model_term(k1, k2, n1, n2)});
        end
    endtask

    // Ends on the posedge where the request is accepted.
    task automatic send_req(input int k1, input int k2, input bit col);
        int n;
        @(negedge clk);
        req_k1_i    = 3'(k1);
        req_k2_i    = 3'(k2);
        req_col_i   = col;
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("req_ready_wait", 64'(req_ready_o), 64'(1));
        @(posedge clk);
    endtask

    // Called right after the accepting posedge; cyc counts posedges since it.
    task automatic collect(input int stop_at, input bit stall, input bit drop_valid);
        int cyc, got, rdy_bad;
        bit first_seen, held, done;
        logic [EW:0]   hv;
        logic [EW-1:0] e;
        cyc = 0; got = 0; rdy_bad = 0;
        first_seen = 0; held = 0; done = 0;
        hv = '0;
        while (!done) begin
            @(negedge clk);
            if (cyc == 0) begin
                if (drop_valid) req_valid_i = 1'b0;
                else begin
                    req_k1_i  = next_k1;
                    req_k2_i  = next_k2;
                    req_col_i = next_col;
                end
            end
            if (held)
                check("stall_hold", 64'({out_valid_o, out_n1_o, out_n2_o, out_last_o, out_term_o}), 64'(hv));
            if (out_valid_o && !first_seen) begin
                first_seen = 1;
                check("first_latency", 64'(cyc), 64'(3));
            end
            if (req_ready_o) rdy_bad++;
            out_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid_o && out_ready_i) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("term", 64'({out_n1_o, out_n2_o, out_last_o, out_term_o}), 64'(e));
                if (got < 64) begin
                    seq_term[got] = out_term_o;
                    seq_n1[got]   = out_n1_o;
                    seq_n2[got]   = out_n2_o;
                end
                got++;
                if (out_last_o || got == stop_at) done = 1;
            end
            held = out_valid_o && !out_ready_i;
            hv   = {out_valid_o, out_n1_o, out_n2_o, out_last_o, out_term_o};
            cyc++;
            if (!done && cyc > 3000) begin
                check("stream_timeout", 64'(got), 64'(stop_at));
                done = 1;
            end
        end
        if (stop_at == 64) begin
            check("handshake_count", 64'(got), 64'(64));
            check("ready_low_busy", 64'(rdy_bad), 64'(0));
            @(negedge clk);
            check("ready_after_last", 64'(req_ready_o), 64'(1));
        end
    endtask

    initial begin
        int bad;
        int rk1, rk2;
        bit rcol;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_k1_i    = '0;
        req_k2_i    = '0;
        req_col_i   = 1'b0;
        out_ready_i = 1'b1;
        next_k1     = '0;
        next_k2     = '0;
        next_col    = 1'b0;

        #12;
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_out_last",  64'(out_last_o),  64'(0));
        check("rst_out_term",  64'(out_term_o),  64'(0));
        check("rst_out_n1",    64'(out_n1_o),    64'(0));
        check("rst_out_n2",    64'(out_n2_o),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready_o), 64'(1));

        // (5,6) row-major, no stall
        push_stream(5, 6, 0);
        send_req(5, 6, 0);
        collect(64, 0, 1);
        check("k56_n00", 64'(seq_term[0]), 64'(t32(54)));
`ifdef DCT_BASIS_ROUND_EN
        check("k56_n11", 64'(seq_term[9]), 64'(t32(232)));
`else
        check("k56_n11", 64'(seq_term[9]), 64'(t32(231)));
`endif
        check("k56_n10", 64'(seq_term[8]), 64'(t32(-96)));
        check("k56_last_idx", 64'({seq_n1[63], seq_n2[63]}), 64'(6'o77));
        for (int i = 0; i < 64; i++) row_term[i] = seq_term[i];

        // DC basis: every term is 128
        push_stream(0, 0, 0);
        send_req(0, 0, 0);
        collect(64, 0, 1);
        bad = 0;
        for (int i = 0; i < 64; i++) if (seq_term[i] !== t32(128)) bad++;
        check("dc_all_128", 64'(bad), 64'(0));

        // (5,6) column-major is the transpose of the row-major run
        push_stream(5, 6, 1);
        send_req(5, 6, 1);
        collect(64, 0, 1);
        check("col_second_idx", 64'({seq_n1[1], seq_n2[1]}), 64'(6'o10));
        check("col_second_term", 64'(seq_term[1]), 64'(t32(-96)));
        bad = 0;
        for (int i = 0; i < 64; i++) if (seq_term[i] !== row_term[(i % 8) * 8 + i / 8]) bad++;
        check("col_transpose", 64'(bad), 64'(0));

        // Random requests with random backpressure
        for (int r = 0; r < 5; r++) begin
            rk1  = int'($urandom_range(0, 7));
            rk2  = int'($urandom_range(0, 7));
            rcol = 1'($urandom_range(0, 1));
            push_stream(rk1, rk2, rcol);
            send_req(rk1, rk2, rcol);
            collect(64, 1, 1);
        end

        // req_valid held high: second request waits for IDLE
        next_k1  = 3'($urandom_range(0, 7));
        next_k2  = 3'($urandom_range(0, 7));
        next_col = 1'($urandom_range(0, 1));
        push_stream(3, 1, 0);
        send_req(3, 1, 0);
        collect(64, 1, 0);
        push_stream(int'(next_k1), int'(next_k2), next_col);
        @(posedge clk);
        collect(64, 1, 1);

        // Reset in the middle of a stream
        push_stream(5, 6, 0);
        send_req(5, 6, 0);
        collect(20, 0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid_o), 64'(0));
        check("midrst_last",  64'(out_last_o),  64'(0));
        check("midrst_term",  64'(out_term_o),  64'(0));
        check("midrst_ready", 64'(req_ready_o), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_stream(2, 7, 0);
        send_req(2, 7, 0);
        collect(64, 1, 1);
        check("restart_first_idx", 64'({seq_n1[0], seq_n2[0]}), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
